// File: rtl/truthtable_sweep_ctrl_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// The FSM state encoding, the row geometry and the default expected pattern.
package truthtable_sweep_ctrl_pkg;

    localparam int ROWS  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam int ERR_W = 4;

    localparam logic [ROWS-1:0] DEFAULT_PATTERN = 8'h4B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/truthtable_sweep_ctrl_settle.sv
// Loadable down-counter that measures the settle time of one row.
// It stops at zero, and o_zero marks the cycle in which f is sampled.
module tt_settle_counter
    import truthtable_sweep_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truthtable_sweep_ctrl.sv
// Self-check sequencer for a 3-input truth-table block: it walks rows 0..7,
// samples f after a settle time and compares each sample to an expected pattern.
module truthtable_sweep_ctrl
    import truthtable_sweep_ctrl_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 1,
    parameter logic [ROWS-1:0] RESET_PATTERN = DEFAULT_PATTERN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_cfg_we,
    input  logic [ROWS-1:0]  i_cfg_pattern,
    input  logic             i_f,
    output logic             o_x3,
    output logic             o_x2,
    output logic             o_x1,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ROWS-1:0]  o_mismatch_mask,
    output logic [ERR_W-1:0] o_err_count
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SETTLE_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [ROWS-1:0]  r_expected;
    logic [ROWS-1:0]  r_mask;
    logic [ERR_W-1:0] r_err;
    logic             r_pass;

    logic             w_idle;
    logic             w_accept;
    logic             w_load;
    logic             w_sample;
    logic             w_mis;
    logic             w_cnt_zero;
    logic [ERR_W-1:0] w_err_nxt;

    tt_settle_counter u_settle (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (SETTLE),
        .o_zero     (w_cnt_zero)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && i_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_sample = 1'b1;
                    if (r_idx == LAST_ROW) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_mis     = w_sample && (i_f != r_expected[r_idx]);
    assign w_err_nxt = r_err + {{(ERR_W-1){1'b0}}, w_mis};

    // Pass is resolved on the edge into DONE so it is already valid in the done cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx      <= '0;
            r_expected <= RESET_PATTERN;
            r_mask     <= '0;
            r_err      <= '0;
            r_pass     <= 1'b0;
        end else begin
            if (w_idle && i_cfg_we) begin
                r_expected <= i_cfg_pattern;
            end
            if (w_accept) begin
                r_idx  <= '0;
                r_mask <= '0;
                r_err  <= '0;
                r_pass <= 1'b0;
            end else if (w_sample) begin
                if (w_mis) begin
                    r_mask[r_idx] <= 1'b1;
                end
                r_err <= w_err_nxt;
                if (r_idx == LAST_ROW) begin
                    r_pass <= (w_err_nxt == '0);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_x3            = r_idx[2];
    assign o_x2            = r_idx[1];
    assign o_x1            = r_idx[0];
    assign o_busy          = (r_state == ST_RUN);
    assign o_done          = (r_state == ST_DONE);
    assign o_pass          = r_pass;
    assign o_mismatch_mask = r_mask;
    assign o_err_count     = r_err;

endmodule

// File: tb/tb_truthtable_sweep_ctrl.sv
// Randomized bench for truthtable_sweep_ctrl: two instances (settle 1 and settle 0)
// each driving a modelled truth-table block, checked against a row-level reference.
module tb_truthtable_sweep_ctrl;

    localparam int LIMIT = 300;
    localparam int S_TAB [2] = '{1, 0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       start = '0;
    logic [1:0]       cfg_we = '0;
    logic [7:0]       pattern = '0;
    logic [1:0][7:0]  ftab = '0;
    logic [1:0]       fv;
    logic [1:0][2:0]  xv;
    logic [1:0]       busy, done, pass;
    logic [1:0][7:0]  mask;
    logic [1:0][3:0]  errc;

    logic [7:0] exp_pat [2] = '{8'h4B, 8'h4B};
    int n_tests = 0;
    int n_fail  = 0;

    assign fv[0] = ftab[0][xv[0]];
    assign fv[1] = ftab[1][xv[1]];

    truthtable_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
        .i_clk(clk), .i_reset(reset), .i_start(start[0]), .i_cfg_we(cfg_we[0]),
        .i_cfg_pattern(pattern), .i_f(fv[0]),
        .o_x3(xv[0][2]), .o_x2(xv[0][1]), .o_x1(xv[0][0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
        .o_mismatch_mask(mask[0]), .o_err_count(errc[0])
    );

    truthtable_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_s0 (
        .i_clk(clk), .i_reset(reset), .i_start(start[1]), .i_cfg_we(cfg_we[1]),
        .i_cfg_pattern(pattern), .i_f(fv[1]),
        .o_x3(xv[1][2]), .o_x2(xv[1][1]), .o_x1(xv[1][0]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
        .o_mismatch_mask(mask[1]), .o_err_count(errc[1])
    );

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int popcnt(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk_idle_reset(input int d);
        chk("rst_busy", busy[d], 0);
        chk("rst_done", done[d], 0);
        chk("rst_pass", pass[d], 0);
        chk("rst_mask", mask[d], 0);
        chk("rst_err",  errc[d], 0);
        chk("rst_x",    xv[d], 0);
    endtask

    // One full sweep on instance d. Optionally writes a pattern with start, and
    // optionally pokes start / cfg_we(8'h00) at cycle 5 to show they are ignored.
    task automatic sweep(input int d, input bit do_cfg, input logic [7:0] pat,
                         input bit mid_start, input bit mid_cfg);
        int s = S_TAB[d];
        int cyc;
        int dcyc = -1;
        logic [7:0] exp_mask;
        @(negedge clk);
        start[d] = 1'b1;
        cfg_we[d] = do_cfg;
        pattern = pat;
        if (do_cfg) exp_pat[d] = pat;
        @(posedge clk); #1;
        start[d] = 1'b0;
        cfg_we[d] = 1'b0;
        exp_mask = ftab[d] ^ exp_pat[d];
        cyc = 1;
        for (int k = 0; k < LIMIT && dcyc < 0; k++) begin
            if (done[d]) begin
                dcyc = cyc;
            end else begin
                if (cyc <= 8 * (s + 1)) begin
                    chk("x_row", xv[d], (cyc - 1) / (s + 1));
                    chk("busy_run", busy[d], 1);
                end
                if (cyc == 5 && (mid_start || mid_cfg)) begin
                    start[d] = mid_start;
                    cfg_we[d] = mid_cfg;
                    pattern = 8'h00;
                end
                @(posedge clk); #1;
                start[d] = 1'b0;
                cfg_we[d] = 1'b0;
                cyc++;
            end
        end
        chk("done_cycle", dcyc, 8 * (s + 1) + 1);
        chk("done_busy", busy[d], 0);
        chk("mask", mask[d], exp_mask);
        chk("err_count", errc[d], popcnt(exp_mask));
        chk("pass", pass[d], (exp_mask == 8'h00) ? 1 : 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("done_single", done[d], 0);
            chk("mask_hold", mask[d], exp_mask);
            chk("pass_hold", pass[d], (exp_mask == 8'h00) ? 1 : 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle_reset(0);
        chk_idle_reset(1);

        // Correct model of the default pattern.
        ftab[0] = 8'h4B;
        sweep(0, 1'b0, 8'h00, 1'b0, 1'b0);
        // f stuck at 0.
        ftab[0] = 8'h00;
        sweep(0, 1'b0, 8'h00, 1'b0, 1'b0);
        // Pattern written together with start; a mid-sweep write is dropped.
        ftab[0] = 8'hFF;
        sweep(0, 1'b1, 8'hFF, 1'b0, 1'b1);
        sweep(0, 1'b0, 8'h00, 1'b0, 1'b0);
        // Restart request mid-sweep is ignored.
        ftab[0] = 8'h5A;
        sweep(0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset during row 4: abort with no done pulse.
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("row4_x", xv[0], 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_pat[0] = 8'h4B;
        exp_pat[1] = 8'h4B;
        chk_idle_reset(0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done[0], 0);
        end

        // Zero settle build: one cycle per row.
        ftab[1] = 8'h4B;
        sweep(1, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int d = it % 2;
            ftab[d] = 8'($urandom);
            sweep(d, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truthtable_sweep_ctrl.md
Name:
truthtable_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 3-input/1-output truth-table function block (x3, x2, x1 -> f). It drives the 8 input combinations in ascending order {x3,x2,x1} = 0..7 and samples f after a programmable settle time. Each sample is compared against a programmable 8-bit expected pattern, and the block reports a per-row mismatch mask, an error count and pass/fail. It sits beside the combinational truth-table block as its built-in self-check controller.

Parameters:
SETTLE_CYCLES, 1, cycles x is held before f is sampled; legal range 0..15.
RESET_PATTERN, 8'h4B, expected pattern loaded at reset; bit i = expected f for {x3,x2,x1}=i.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
cfg_we  input  1  write cfg_pattern into the expected register; accepted only in IDLE
cfg_pattern  input  8  new expected pattern
f  input  1  output of the truth-table block under control
x3  output  1  input MSB to the truth-table block (registered)
x2  output  1  registered
x1  output  1  input LSB (registered)
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  high when the last completed sweep had zero mismatches; held until the next accepted start
mismatch_mask  output  8  bit i set if row i mismatched in the last sweep
err_count  output  4  number of mismatching rows, 0..8

Behaviour:
- Reset behaviour (synchronous, active-high):
  - state=IDLE, idx=0, {x3,x2,x1}=3'b000, busy=0, done=0, pass=0, mismatch_mask=0, err_count=0.
  - expected register is set to RESET_PATTERN.
  - reset asserted mid-sweep aborts the sweep immediately; no done pulse is generated.
- States:
  - IDLE: busy=0; x outputs hold their last value.
    - cfg_we=1: the expected register takes cfg_pattern on the next edge.
    - start=1: go to RUN; idx<=0, x<=000, wait counter<=SETTLE_CYCLES, mismatch_mask<=0, err_count<=0, pass<=0, busy<=1.
  - RUN: x = idx (registered).
    - wait counter>0: decrement it.
    - wait counter==0 (sample cycle): compare f with expected[idx].
      - Mismatch: set mismatch_mask[idx] and increment err_count.
      - idx<7: idx<=idx+1, x<=idx+1, counter reloads to SETTLE_CYCLES.
      - idx==7: go to DONE.
  - DONE: lasts one cycle; done=1, busy=0, pass=(err_count==0). Go to IDLE.
- Timing:
  - Each row is held for exactly SETTLE_CYCLES+1 cycles, and f is sampled on the last of them.
  - With SETTLE_CYCLES=0, f is sampled in the same cycle the row is first presented.
  - start accepted at edge T → done high in cycle T+8*(SETTLE_CYCLES+1)+1.
- Boundary conditions:
  - start while busy or in DONE: ignored, not queued.
  - cfg_we while not IDLE: ignored, so the expected pattern cannot change mid-sweep.
  - cfg_we and start together in IDLE: the pattern is written and the sweep starts on the same edge; the sweep uses the new pattern.
  - idx is 3 bits; row 7 is the last row, and it is not allowed to wrap to 0 within a sweep.
  - err_count saturates naturally at 8 (4 bits, no overflow possible).
  - Results (mask, count, pass) are stable from the done cycle until the next accepted start.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DONE)
  - ROWS=8 and IDX_W=3
  - the default pattern constant 8'h4B
- One natural sub-module, tt_settle_counter: a loadable down-counter with a zero flag.
- The FSM, row index and result registers stay in the top level.

Test Plan:
1. Reset, then start with f driven by a correct model of pattern 8'h4B, SETTLE_CYCLES=1 → x steps 0..7 holding 2 cycles each; done on cycle 17 after start; pass=1, mask=8'h00, err_count=0.
2. Same setup, but f forced to 0 always → mask=8'h4B, err_count=4, pass=0.
3. In IDLE, cfg_we with 8'hFF and start in the same cycle; f forced to 1 → pass=1, mask=0. A subsequent cfg_we during busy with 8'h00 is ignored (a re-run still passes).
4. start pulsed again at cycle 5 of a sweep → no restart; a single done on the original schedule.
5. Reset asserted during row 4 → next cycle busy=0, x=000, mask=0, err_count=0, and no done pulse.
6. SETTLE_CYCLES=0 build, correct model → x changes every cycle; done 9 cycles after start; pass=1.
